// File: rtl/rot_cmd_feeder.sv
// rot_cmd_feeder: buffers rotate commands in a small FIFO, issues them one at
// a time to an external 32-bit right barrel rotator, captures the rotator's
// output one cycle later and presents it on a valid/ready result port.
// Left rotates are turned into the equivalent right-rotate amount at pop time.
module rot_cmd_feeder #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [31:0]                cmd_data_i,
    input  logic [4:0]                 cmd_amt_i,
    input  logic                       cmd_left_i,
    input  logic [TAG_W-1:0]           cmd_tag_i,
    output logic [31:0]                rot_a_o,
    output logic [4:0]                 rot_amt_o,
    input  logic [31:0]                rot_y_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [31:0]                res_data_o,
    output logic [TAG_W-1:0]           res_tag_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Command storage (raw amount and direction; mapping happens at pop)
    logic [31:0]      data_mem_q [DEPTH];
    logic [4:0]       amt_mem_q  [DEPTH];
    logic             left_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    state_t           state_q, state_d;
    logic [31:0]      rot_a_q, rot_a_d;
    logic [4:0]       rot_amt_q, rot_amt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_valid_q, res_valid_d;

    logic             push_s;
    logic             pop_s;
    logic [4:0]       head_amt_s;
    logic             head_left_s;
    logic [5:0]       left_amt_s;
    logic [4:0]       mapped_amt_s;

    assign cmd_ready_o  = (level_q != LVL_W'(DEPTH));
    assign push_s       = cmd_valid_i && cmd_ready_o;

    // A left rotate by n equals a right rotate by (32 - n) mod 32; n = 0 stays 0.
    assign head_amt_s   = amt_mem_q[rd_ptr_q];
    assign head_left_s  = left_mem_q[rd_ptr_q];
    assign left_amt_s   = 6'd32 - {1'b0, head_amt_s};
    assign mapped_amt_s = head_left_s ? left_amt_s[4:0] : head_amt_s;

    // FIFO storage write; entries need no reset since level gates every read
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            data_mem_q[wr_ptr_q] <= cmd_data_i;
            amt_mem_q[wr_ptr_q]  <= cmd_amt_i;
            left_mem_q[wr_ptr_q] <= cmd_left_i;
            tag_mem_q[wr_ptr_q]  <= cmd_tag_i;
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Issue FSM next-state: pop in IDLE, capture rotator output in ISSUE, hold in RESP
    always_comb begin
        state_d     = state_q;
        rot_a_d     = rot_a_q;
        rot_amt_d   = rot_amt_q;
        tag_d       = tag_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        res_valid_d = res_valid_q;
        pop_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != {LVL_W{1'b0}}) begin
                    pop_s     = 1'b1;
                    rot_a_d   = data_mem_q[rd_ptr_q];
                    rot_amt_d = mapped_amt_s;
                    tag_d     = tag_mem_q[rd_ptr_q];
                    state_d   = ISSUE;
                end else begin
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                // Rotator latched our operands at the mid-cycle negedge
                res_data_d  = rot_y_i;
                res_tag_d   = tag_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, pointer and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            state_q     <= IDLE;
            rot_a_q     <= 32'd0;
            rot_amt_q   <= 5'd0;
            tag_q       <= {TAG_W{1'b0}};
            res_data_q  <= 32'd0;
            res_tag_q   <= {TAG_W{1'b0}};
            res_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            rot_a_q     <= rot_a_d;
            rot_amt_q   <= rot_amt_d;
            tag_q       <= tag_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign rot_a_o     = rot_a_q;
    assign rot_amt_o   = rot_amt_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_tag_o   = res_tag_q;
    assign level_o     = level_q;
    assign busy_o      = (state_q != IDLE) || (level_q != {LVL_W{1'b0}});

endmodule

// File: tb/tb_rot_cmd_feeder.sv
// Testbench for rot_cmd_feeder: models the downstream rotator (negedge
// registered right rotate) and checks results against a queue-based
// reference that rotates directly by the requested direction and distance.
module tb_rot_cmd_feeder;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_data;
    logic [4:0]       cmd_amt;
    logic             cmd_left;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      rot_a;
    logic [4:0]       rot_amt;
    logic [31:0]      rot_y;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             busy;
    logic [LVL_W-1:0] level;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rot_cmd_feeder #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_data_i(cmd_data), .cmd_amt_i(cmd_amt), .cmd_left_i(cmd_left), .cmd_tag_i(cmd_tag),
        .rot_a_o(rot_a), .rot_amt_o(rot_amt), .rot_y_i(rot_y),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_tag_o(res_tag),
        .busy_o(busy), .level_o(level)
    );

    // Downstream right rotator: registers its result on the falling edge
    always @(negedge clk) begin
        logic [63:0] t;
        t = {rot_a, rot_a} >> rot_amt;
        rot_y <= t[31:0];
    end

    // Reference: rotate in the requested direction directly
    function automatic logic [31:0] exp_rot(input logic [31:0] d, input logic [4:0] n, input logic left);
        logic [63:0] t;
        if (left) begin
            t = {d, d} << n;
            return t[63:32];
        end else begin
            t = {d, d} >> n;
            return t[31:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] d, input logic [4:0] a, input logic l,
                            input logic [TAG_W-1:0] t, output bit acc);
        exp_t e;
        cmd_data = d; cmd_amt = a; cmd_left = l; cmd_tag = t; cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            if (cmd_ready) begin
                e.data = exp_rot(d, a, l);
                e.tag  = t;
                exp_q.push_back(e);
                acc = 1'b1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: cmd not accepted, got 0 want 1");
        end
    endtask

    task automatic get_result(output logic [31:0] d, output logic [TAG_W-1:0] t, output bit got);
        res_ready = 1'b1;
        got = 1'b0;
        d = 32'd0; t = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (res_valid) begin
                d = res_data; t = res_tag; got = 1'b1;
            end
            tick();
        end
        res_ready = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL result_timeout: res_valid got 0 want 1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (level !== '0)       begin bad++; $display("FAIL rst_level got %0d want 0", level); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if ({rot_a, rot_amt} !== 37'd0) begin bad++; $display("FAIL rst_rot got %h/%0d want 0/0", rot_a, rot_amt); end
        total++; if ({res_data, res_tag} !== {32'd0, {TAG_W{1'b0}}}) begin bad++; $display("FAIL rst_res got %h/%0d want 0/0", res_data, res_tag); end
    endtask

    task automatic test_right_rotate();
        logic [31:0] held;
        res_ready = 1'b0;
        cmd_data = 32'h8000_0001; cmd_amt = 5'd1; cmd_left = 1'b0; cmd_tag = 4'd3; cmd_valid = 1'b1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL right_cmd_ready got %b want 1", cmd_ready); end
        tick();                       // T: pushed
        cmd_valid = 1'b0;
        total++; if (level !== LVL_W'(1)) begin bad++; $display("FAIL right_level_T got %0d want 1", level); end
        tick();                       // T+1: popped
        total++; if (rot_a !== 32'h8000_0001 || rot_amt !== 5'd1) begin bad++; $display("FAIL right_issue got %h/%0d want 80000001/1", rot_a, rot_amt); end
        total++; if (res_valid !== 1'b0 || busy !== 1'b1 || level !== '0) begin bad++; $display("FAIL right_T1 got v=%b busy=%b lvl=%0d want 0/1/0", res_valid, busy, level); end
        tick();                       // T+2: result
        total++; if (res_valid !== 1'b1 || res_data !== 32'hC000_0000 || res_tag !== 4'd3) begin bad++; $display("FAIL right_result got %b/%h/%0d want 1/c0000000/3", res_valid, res_data, res_tag); end
        held = res_data;
        tick(); tick();
        total++; if (res_valid !== 1'b1 || res_data !== held) begin bad++; $display("FAIL right_hold got %b/%h want 1/%h", res_valid, res_data, held); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL right_release got %b want 0", res_valid); end
    endtask

    task automatic test_left_rotate();
        bit acc;
        exp_q.delete();
        res_ready = 1'b0;
        send_cmd(32'h0000_00F0, 5'd4, 1'b1, 4'd9, acc);
        tick();
        total++; if (rot_amt !== 5'd28) begin bad++; $display("FAIL left_amt got %0d want 28", rot_amt); end
        tick();
        total++; if (res_valid !== 1'b1 || res_data !== 32'h0000_0F00 || res_tag !== 4'd9) begin bad++; $display("FAIL left_result got %b/%h/%0d want 1/00000f00/9", res_valid, res_data, res_tag); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_amount_edges();
        logic [31:0] td [4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001, 32'hABCD_1234};
        logic [4:0]  ta [4] = '{5'd0, 5'd0, 5'd31, 5'd16};
        logic        tl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0]  tm [4] = '{5'd0, 5'd0, 5'd31, 5'd16};
        logic [31:0] tr [4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0002, 32'h1234_ABCD};
        bit acc, got;
        logic [31:0] d;
        logic [TAG_W-1:0] t;
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            send_cmd(td[i], ta[i], tl[i], TAG_W'(i + 5), acc);
            tick();
            total++; if (rot_amt !== tm[i]) begin bad++; $display("FAIL edge%0d_amt got %0d want %0d", i, rot_amt, tm[i]); end
            get_result(d, t, got);
            if (got && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++; if (d !== tr[i] || d !== e.data || t !== e.tag) begin bad++; $display("FAIL edge%0d_result got %h/%0d want %h/%0d", i, d, t, tr[i], e.tag); end
            end
        end
    endtask

    task automatic test_back_to_back();
        // Backpressure: hold results, stream DEPTH+2 commands, then drain
        int acc_cnt = 0;
        int late = 0;
        bit got;
        logic [31:0] d;
        logic [TAG_W-1:0] t;
        exp_t e;
        exp_q.delete();
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cmd_data = $urandom; cmd_amt = 5'($urandom_range(0, 31)); cmd_left = 1'($urandom_range(0, 1));
            cmd_tag = TAG_W'(i + 1); cmd_valid = 1'b1;
            if (cmd_ready) begin
                e.data = exp_rot(cmd_data, cmd_amt, cmd_left);
                e.tag  = cmd_tag;
                exp_q.push_back(e);
                acc_cnt++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        total++; if (acc_cnt != DEPTH + 1) begin bad++; $display("FAIL bp_accepted got %0d want %0d", acc_cnt, DEPTH + 1); end
        total++; if (cmd_ready !== 1'b0 || level !== LVL_W'(DEPTH)) begin bad++; $display("FAIL bp_full got rdy=%b lvl=%0d want 0/%0d", cmd_ready, level, DEPTH); end
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_first_waiting got %b want 1", res_valid); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            get_result(d, t, got);
            if (got && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++; if (d !== e.data || t !== e.tag) begin bad++; $display("FAIL bp_result%0d got %h/%0d want %h/%0d", i, d, t, e.data, e.tag); end
            end
        end
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (res_valid) late++;
            tick();
        end
        res_ready = 1'b0;
        total++; if (late != 0 || busy !== 1'b0) begin bad++; $display("FAIL bp_extra got late=%0d busy=%b want 0/0", late, busy); end
    endtask

    task automatic test_random();
        localparam int N = 40;
        int got_cnt = 0;
        int errs = 0;
        exp_q.delete();
        res_ready = 1'b0;
        fork
            begin
                bit acc;
                for (int i = 0; i < N; i++) begin
                    int gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) tick();
                    send_cmd($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), TAG_W'(i), acc);
                end
            end
            begin
                bit pend = 1'b0;
                logic [31:0] pd = 32'd0;
                exp_t e;
                for (int c = 0; c < 3000 && got_cnt < N; c++) begin
                    res_ready = 1'($urandom_range(0, 1));
                    if (pend && (res_valid !== 1'b1 || res_data !== pd)) begin
                        errs++;
                        $display("FAIL rand_hold got %b/%h want 1/%h", res_valid, res_data, pd);
                    end
                    if (res_valid && res_ready) begin
                        if (exp_q.size() == 0) begin
                            errs++;
                            $display("FAIL rand_unexpected got %h want none", res_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (res_data !== e.data || res_tag !== e.tag) begin
                                errs++;
                                $display("FAIL rand_result%0d got %h/%0d want %h/%0d", got_cnt, res_data, res_tag, e.data, e.tag);
                            end
                        end
                        got_cnt++;
                        pend = 1'b0;
                    end else begin
                        pend = res_valid;
                        pd   = res_data;
                    end
                    tick();
                end
                res_ready = 1'b0;
            end
        join
        total++; if (got_cnt != N) begin bad++; $display("FAIL rand_count got %0d want %0d", got_cnt, N); end
        total++; if (errs != 0) begin bad++; $display("FAIL rand_errors got %0d want 0", errs); end
    endtask

    task automatic test_reset_mid();
        bit acc, got;
        int late = 0;
        logic [31:0] d;
        logic [TAG_W-1:0] t;
        exp_t e;
        exp_q.delete();
        res_ready = 1'b0;
        send_cmd(32'h1111_1111, 5'd3, 1'b0, 4'd1, acc);
        tick(); tick();               // result parked in RESP
        for (int i = 0; i < 3; i++) begin
            cmd_data = 32'hA000_0000 + 32'(i); cmd_amt = 5'd2; cmd_left = 1'b0; cmd_tag = TAG_W'(i + 2); cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        total++; if (level !== LVL_W'(3)) begin bad++; $display("FAIL mid_level3 got %0d want 3", level); end
        res_ready = 1'b1;
        tick();                       // handshake, back to IDLE
        res_ready = 1'b0;
        tick();                       // pop first queued -> ISSUE
        total++; if (level !== LVL_W'(2) || rot_a !== 32'hA000_0000) begin bad++; $display("FAIL mid_issue got lvl=%0d a=%h want 2/a0000000", level, rot_a); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (level !== '0 || res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_reset got lvl=%0d v=%b busy=%b rdy=%b want 0/0/0/1", level, res_valid, busy, cmd_ready); end
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (res_valid) late++;
            tick();
        end
        res_ready = 1'b0;
        total++; if (late != 0) begin bad++; $display("FAIL mid_stale got %0d want 0", late); end
        exp_q.delete();
        send_cmd(32'h0F0F_0000, 5'd8, 1'b1, 4'd14, acc);
        get_result(d, t, got);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++; if (d !== e.data || t !== e.tag) begin bad++; $display("FAIL mid_recover got %h/%0d want %h/%0d", d, t, e.data, e.tag); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = 32'd0; cmd_amt = 5'd0; cmd_left = 1'b0;
        cmd_tag = '0; res_ready = 1'b0;
        test_reset();
        test_right_rotate();
        test_left_rotate();
        test_amount_edges();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
